// File: rtl/stitch_pipeline_vr.sv
`default_nettype none
// ============================================================================
// Module   : stitch_pipeline_vr
// Purpose  : Valid/ready add pipeline. Slot p0 registers the input item
//            unchanged. Each following slot p1..pSTAGES registers the
//            previous slot's data plus STEP, with silent wrap-around.
//            Back-pressure is a combinational per-slot ready chain, so an
//            empty slot always accepts upstream data (bubbles collapse).
//            flush clears every valid bit synchronously. rst clears all
//            state asynchronously.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            flush           - synchronous clear of all valid bits
//            in_valid/in_ready/in_data     - upstream handshake and item
//            out_valid/out_ready/out_data  - downstream handshake and result
//            occupancy       - number of valid slots currently held
// Revision : 1.0 - initial release
// ============================================================================
module stitch_pipeline_vr #(
  parameter int          WIDTH  = 32,
  parameter int          STAGES = 2,
  parameter int unsigned STEP   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(STAGES+2)-1:0]   occupancy
);

  localparam int              OCC_W  = $clog2(STAGES+2);
  localparam logic [WIDTH-1:0] C_STEP = WIDTH'(STEP);

  logic [WIDTH-1:0]  r_data [0:STAGES];
  logic [STAGES:0]   r_valid;
  logic [STAGES:0]   w_rdy;
  logic [OCC_W-1:0]  w_occ;

  // Ready chain evaluated from the output end backwards. A running term is
  // used so every bit of w_rdy is only written here, never read back.
  always_comb begin
    logic w_run;
    w_rdy = '0;
    w_run = out_ready | ~r_valid[STAGES];
    w_rdy[STAGES] = w_run;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_run    = ~r_valid[i] | w_run;
      w_rdy[i] = w_run;
    end
  end

  // Population count of the valid bits.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i <= STAGES; i++) begin
      w_occ = w_occ + {{(OCC_W-1){1'b0}}, r_valid[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i <= STAGES; i++) begin
        r_data[i] <= '0;
      end
    end else if (flush) begin
      // Data registers are left as they are; only validity matters.
      r_valid <= '0;
    end else begin
      // Slot 0 captures the raw input item.
      if (w_rdy[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= in_data;
        end
      end
      // Later slots add STEP to the previous slot while advancing.
      for (int i = 1; i <= STAGES; i++) begin
        if (w_rdy[i]) begin
          r_valid[i] <= r_valid[i-1];
          if (r_valid[i-1]) begin
            r_data[i] <= r_data[i-1] + C_STEP;
          end
        end
      end
    end
  end

  assign in_ready  = w_rdy[0] & ~flush;
  assign out_valid = r_valid[STAGES] & ~flush;
  assign out_data  = r_data[STAGES];
  assign occupancy = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_stitch_pipeline_vr.sv
`default_nettype none
// ============================================================================
// Module   : tb_stitch_pipeline_vr
// Purpose  : Self-checking bench for stitch_pipeline_vr. Instance A uses the
//            default configuration (WIDTH=32, STAGES=2, STEP=1) with a
//            queue scoreboard; instance B uses STAGES=4, STEP=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stitch_pipeline_vr;

  logic        clk;
  logic        rst;

  // Instance A
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  // Instance B
  logic        b_flush;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [31:0] b_in_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [31:0] b_out_data;
  logic [2:0]  b_occupancy;

  int checks;
  int errors;

  logic [31:0] sb [$];

  stitch_pipeline_vr #(.WIDTH(32), .STAGES(2), .STEP(1)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  stitch_pipeline_vr #(.WIDTH(32), .STAGES(4), .STEP(3)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .occupancy (b_occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard for instance A: sampled on the falling edge, where inputs
  // driven after the rising edge are stable.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_output: got %h, expected no output", out_data);
        end else begin
          logic [31:0] exp_v;
          exp_v = sb.pop_front();
          if (out_data !== exp_v) begin
            errors++;
            $display("FAIL sb_data: got %h, expected %h", out_data, exp_v);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_data + 32'd2);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rst_out_data: got %h, expected 0", out_data); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occupancy: got %0d, expected 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, expected 1", in_ready); end
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_latency;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'd5;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready: got %b, expected 1", in_ready); end
    tick; in_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      checks++; if (occupancy !== 2'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle%0d: occ %0d valid %b, expected occ 1 valid 0", c, occupancy, out_valid); end
      tick;
    end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd7 || occupancy !== 2'd1) begin errors++; $display("FAIL lat_cycle3: valid %b data %0d occ %0d, expected 1 7 1", out_valid, out_data, occupancy); end
    tick;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL lat_cycle4: valid %b occ %0d, expected 0 0", out_valid, occupancy); end
  endtask

  task automatic test_wrap;
    int n;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    tick; in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick; n++; end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0001) begin errors++; $display("FAIL wrap_a: valid %b data %h, expected 1 00000001", out_valid, out_data); end
    // Instance B: STAGES=4, STEP=3
    b_in_valid = 1'b1; b_in_data = 32'd10;
    tick; b_in_valid = 1'b0;
    n = 1;
    while (!b_out_valid && n < 20) begin tick; n++; end
    checks++; if (n != 5) begin errors++; $display("FAIL wrap_b_latency: got %0d cycles, expected 5", n); end
    checks++; if (b_out_data !== 32'd22) begin errors++; $display("FAIL wrap_b_data: got %0d, expected 22", b_out_data); end
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_data = k;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept%0d: in_ready %b, expected 1", k, in_ready); end
      tick;
    end
    in_data = 32'd4;
    #1;
    checks++; if (in_ready !== 1'b0 || occupancy !== 2'd3) begin errors++; $display("FAIL bp_full: in_ready %b occ %0d, expected 0 3", in_ready, occupancy); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd3) begin errors++; $display("FAIL bp_head: valid %b data %0d, expected 1 3", out_valid, out_data); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_same_cycle_accept: in_ready %b, expected 1", in_ready); end
    tick; in_valid = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== k) begin errors++; $display("FAIL bp_drain%0d: valid %b data %0d, expected 1 %0d", k, out_valid, out_data, k); end
      tick;
    end
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL bp_empty: valid %b occ %0d, expected 0 0", out_valid, occupancy); end
  endtask

  task automatic test_bubble;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd10;
    tick; in_valid = 1'b0;
    tick; tick;
    checks++; if (occupancy !== 2'd1 || out_valid !== 1'b1 || out_data !== 32'd12) begin errors++; $display("FAIL bub_resident: occ %0d valid %b data %0d, expected 1 1 12", occupancy, out_valid, out_data); end
    in_valid = 1'b1; in_data = 32'd20;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_accept: in_ready %b, expected 1", in_ready); end
    tick; in_valid = 1'b0;
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b1) begin errors++; $display("FAIL bub_p0: occ %0d in_ready %b, expected 2 1", occupancy, in_ready); end
    tick;
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b1) begin errors++; $display("FAIL bub_p1: occ %0d in_ready %b, expected 2 1", occupancy, in_ready); end
    in_valid = 1'b1; in_data = 32'd30;
    tick; in_valid = 1'b0;
    checks++; if (occupancy !== 2'd3 || in_ready !== 1'b0) begin errors++; $display("FAIL bub_full: occ %0d in_ready %b, expected 3 0", occupancy, in_ready); end
    out_ready = 1'b1;
    for (int n = 0; n < 10 && occupancy != 2'd0; n++) tick;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL bub_drain: occ %0d, expected 0", occupancy); end
  endtask

  task automatic test_flush;
    int n;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'd100 + k;
      tick;
    end
    flush = 1'b1; in_data = 32'd200;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle: in_ready %b out_valid %b, expected 0 0", in_ready, out_valid); end
    tick; flush = 1'b0; in_valid = 1'b0;
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_after: occ %0d out_valid %b, expected 0 0", occupancy, out_valid); end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'd50;
    tick; in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick; n++; end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd52) begin errors++; $display("FAIL flush_resume: valid %b data %0d, expected 1 52", out_valid, out_data); end
    tick;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'd70 + k;
      tick;
    end
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL arst_prefill: occ %0d, expected 3", occupancy); end
    #1 rst = 1'b1;
    #1;
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'd0) begin errors++; $display("FAIL arst_immediate: occ %0d valid %b data %h, expected 0 0 0", occupancy, out_valid, out_data); end
    tick;
    rst = 1'b0;
    out_ready = 1'b1;
    tick;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL arst_after: occ %0d, expected 0", occupancy); end
  endtask

  task automatic test_back_to_back;
    int outs;
    outs = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin in_valid = 1'b1; in_data = $urandom; end
      else in_valid = 1'b0;
      #1;
      if (c < 8) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d: got %b, expected 1", c, in_ready); end
      end
      if (out_valid) outs++;
      tick;
    end
    checks++; if (outs != 8) begin errors++; $display("FAIL b2b_throughput: got %0d outputs, expected 8", outs); end
  endtask

  task automatic test_random;
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      tick;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 10 && occupancy != 2'd0; n++) tick;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rand_drain: occ %0d, expected 0", occupancy); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rand_sb_left: %0d items, expected 0", sb.size()); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    #1;
    test_reset;
    test_latency;
    test_wrap;
    test_backpressure;
    test_bubble;
    test_flush;
    test_async_reset;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
